// File: rtl/spart_pkg.sv
`default_nettype none
// spart_pkg: register map, status bit positions, FSM state codes and reset divisor for spart_fifo.
// Revision 1.0
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;

  localparam int ST_RDA       = 0;
  localparam int ST_TBR       = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [15:0] DIV_RESET_DEFAULT = 16'h0144;

endpackage
`default_nettype wire

// File: rtl/spart_sync_fifo.sv
`default_nettype none
// spart_sync_fifo: single-clock FIFO with wrap-bit pointers and a combinational head output.
// Revision 1.0
module spart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/spart_fifo.sv
`default_nettype none
// spart_fifo: SPART UART with TX/RX FIFOs, 16x oversampling baud generator and 8-bit register bus.
// Revision 1.0
module spart_fifo
  import spart_pkg::*;
#(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rd_acc, wr_acc, stat_wr;
  logic [7:0]           rdata, status;
  logic [15:0]          divisor, div_next, tick_cnt;
  logic                 div_wr, tick;
  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_idle;
  logic                 rx_push, rx_pop, rx_full, rx_empty, rx_done;
  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic [1:0]           tx_state, rx_state;
  logic [3:0]           tx_tcnt, rx_tcnt;
  logic [2:0]           tx_bcnt, rx_bcnt;
  logic [DATA_BITS-1:0] tx_shift, rx_shift;
  logic                 rx_s1, rx_s2;
  logic                 overrun, frame_err, over_set, frame_set;

  assign rd_acc  = iocs && iorw;
  assign wr_acc  = iocs && !iorw;
  assign stat_wr = wr_acc && (ioaddr == ADDR_STAT);
  assign databus = rd_acc ? rdata : 8'hzz;

  assign tx_push = wr_acc && (ioaddr == ADDR_DATA);
  assign rx_pop  = rd_acc && (ioaddr == ADDR_DATA);
  assign rda     = !rx_empty;
  assign tbr     = !tx_full;
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(databus[DATA_BITS-1:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(rx_shift), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    status               = 8'h00;
    status[ST_RDA]       = rda;
    status[ST_TBR]       = tbr;
    status[ST_TX_IDLE]   = tx_idle;
    status[ST_OVERRUN]   = overrun;
    status[ST_FRAME_ERR] = frame_err;
  end

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      ADDR_DATA: if (!rx_empty) rdata[DATA_BITS-1:0] = rx_head;
      ADDR_STAT: rdata = status;
      ADDR_DIVL: rdata = divisor[7:0];
      default:   rdata = divisor[15:8];
    endcase
  end

  always_comb begin
    div_next = divisor;
    div_wr   = 1'b0;
    if (wr_acc && (ioaddr == ADDR_DIVL)) begin
      div_next[7:0] = databus;
      div_wr        = 1'b1;
    end
    if (wr_acc && (ioaddr == ADDR_DIVH)) begin
      div_next[15:8] = databus;
      div_wr         = 1'b1;
    end
  end

  // Tick period is divisor+1 clocks; a divisor write restarts the phase from the new value.
  assign tick = (tick_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor  <= DIV_RESET;
      tick_cnt <= DIV_RESET;
    end else begin
      divisor <= div_next;
      if (div_wr)    tick_cnt <= div_next;
      else if (tick) tick_cnt <= divisor;
      else           tick_cnt <= tick_cnt - 16'd1;
    end
  end

  assign tx_pop = tick && !tx_empty &&
                  ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_tcnt == 4'd15)));

  // txd is a flop with async set so reset forces the line idle without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 3'd0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_shift <= tx_head;
            tx_tcnt  <= 4'd0;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_bcnt  <= 3'd0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (tx_bcnt == LAST_BIT) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bcnt  <= tx_bcnt + 3'd1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end
        end
        default: begin
          tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (!tx_empty) begin
              tx_shift <= tx_head;
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_done   = tick && (rx_state == RX_STOP) && (rx_tcnt == 4'd15);
  assign rx_push   = rx_done && rx_s2;
  assign frame_set = rx_done && !rx_s2;
  assign over_set  = rx_push && rx_full && !(rx_pop && !rx_empty);

  // Start is confirmed mid-bit (8 ticks in); every later sample is 16 ticks apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= 4'd0;
      rx_bcnt  <= 3'd0;
      rx_shift <= '0;
    end else if (tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_tcnt  <= 4'd0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd7) begin
            rx_tcnt <= 4'd0;
            rx_bcnt <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_bcnt == LAST_BIT) rx_state <= RX_STOP;
            else                     rx_bcnt  <= rx_bcnt + 3'd1;
          end
        end
        default: begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (over_set)                              overrun <= 1'b1;
      else if (stat_wr && databus[ST_OVERRUN])   overrun <= 1'b0;
      if (frame_set)                             frame_err <= 1'b1;
      else if (stat_wr && databus[ST_FRAME_ERR]) frame_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_fifo.sv
`default_nettype none
// tb_spart_fifo: directed self-checking bench for spart_fifo.
// Revision 1.0
module tb_spart_fifo;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;
  wire  [7:0] databus;
  wire        rxd;
  logic       rda, tbr, txd;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  assign databus = drv_en ? drv_data : 8'hzz;
  assign rxd     = loop ? txd : rx_drv;

  spart_fifo dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_data = d; drv_en = 1'b1;
    @(negedge clk);
    iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic wait_txd_low();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (txd !== 1'b0 && n < 2000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (32) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (32) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] pat;
    int         low_len, t0, elapsed, polls;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_tbr", 32'(tbr), 1);
    check("rst_rda", 32'(rda), 0);
    rst = 1'b0;
    bus_rd(ADDR_STAT, s); check("rst_status", 32'(s), 'h06);
    bus_rd(ADDR_DIVL, s); check("rst_div_lo", 32'(s), 'h44);
    bus_rd(ADDR_DIVH, s); check("rst_div_hi", 32'(s), 'h01);
    bus_rd(ADDR_DATA, s); check("empty_read", 32'(s), 'h00);

    // Single frame 0x55 at divisor 1: 32 clocks per bit
    bus_wr(ADDR_DIVL, 8'h01);
    bus_wr(ADDR_DIVH, 8'h00);
    bus_rd(ADDR_DIVL, s); check("div_lo_rb", 32'(s), 'h01);
    bus_wr(ADDR_DATA, 8'h55);
    wait_txd_low();
    check("tx_start_seen", 32'(txd), 0);
    low_len = 0;
    while (txd === 1'b0 && low_len < 100) begin
      low_len++;
      @(posedge clk); #1;
    end
    check("tx_start_len", 32'(low_len), 32);
    pat = 8'h55;
    for (int k = 0; k < 8; k++) begin
      repeat (16) @(posedge clk); #1;
      check("tx_bit", 32'(txd), 32'(pat[k]));
      repeat (16) @(posedge clk);
    end
    repeat (16) @(posedge clk); #1;
    check("tx_stop", 32'(txd), 1);
    repeat (40) @(posedge clk);
    bus_rd(ADDR_STAT, s); check("tx_idle_after", 32'(s), 'h06);

    // Fill TX FIFO while ticks are stalled, then release and time the burst
    loop = 1'b1;
    bus_wr(ADDR_DIVH, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        @(negedge clk);
        check("tbr_before_full", 32'(tbr), 1);
      end
      bus_wr(ADDR_DATA, 8'(8'h10 + i));
    end
    @(negedge clk);
    check("tbr_full", 32'(tbr), 0);
    bus_wr(ADDR_DATA, 8'h18);
    bus_wr(ADDR_DIVH, 8'h00);
    t0 = cyc;
    s = 8'h00;
    polls = 0;
    while (s[ST_TX_IDLE] !== 1'b1 && polls < 3000) begin
      bus_rd(ADDR_STAT, s);
      polls++;
    end
    elapsed = cyc - t0;
    check("tx_eight_frames", 32'(elapsed >= 2556 && elapsed <= 2570), 1);
    for (int i = 0; i < 8; i++) begin
      bus_rd(ADDR_DATA, s);
      check("burst_rx_data", 32'(s), 32'(8'h10 + i));
    end
    @(negedge clk);
    check("burst_rx_drained", 32'(rda), 0);

    // Loopback of one character
    bus_wr(ADDR_DATA, 8'hA3);
    polls = 0;
    while (rda !== 1'b1 && polls < 1000) begin
      polls++;
      @(posedge clk); #1;
    end
    check("loop_rda", 32'(rda), 1);
    bus_rd(ADDR_DATA, s); check("loop_data", 32'(s), 'hA3);
    @(negedge clk);
    check("loop_rda_clear", 32'(rda), 0);

    // Overrun: nine characters, no reads
    repeat (100) @(posedge clk);
    loop = 1'b0;
    for (int i = 0; i < 9; i++) send_rx(8'(8'h30 + i), 1'b1);
    repeat (40) @(posedge clk);
    bus_rd(ADDR_STAT, s); check("overrun_status", 32'(s), 'h0F);
    bus_wr(ADDR_STAT, 8'h08);
    bus_rd(ADDR_STAT, s); check("overrun_clear", 32'(s), 'h07);
    for (int i = 0; i < 8; i++) begin
      bus_rd(ADDR_DATA, s);
      check("overrun_data", 32'(s), 32'(8'h30 + i));
    end
    @(negedge clk);
    check("overrun_drained", 32'(rda), 0);

    // Short low glitch, then a frame with a low stop bit
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(posedge clk);
    bus_rd(ADDR_STAT, s); check("glitch_status", 32'(s), 'h06);
    send_rx(8'h5A, 1'b0);
    repeat (60) @(posedge clk);
    bus_rd(ADDR_STAT, s); check("frame_err_status", 32'(s), 'h16);
    bus_wr(ADDR_STAT, 8'h10);
    bus_rd(ADDR_STAT, s); check("frame_err_clear", 32'(s), 'h06);

    // Reset in the middle of a frame of zeros
    bus_wr(ADDR_DATA, 8'h00);
    wait_txd_low();
    repeat (48) @(posedge clk);
    @(negedge clk);
    check("mid_frame_low", 32'(txd), 0);
    #2 rst = 1'b1;
    #1 check("rst_async_txd", 32'(txd), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(ADDR_STAT, s); check("post_rst_status", 32'(s), 'h06);
    bus_rd(ADDR_DIVL, s); check("post_rst_div_lo", 32'(s), 'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
